ads_frame_reader: RTL and testbench

//  Read-side consumer of the HPF sample FIFO in the G729 encoder front end. Waits until a full frame
//  of new samples is buffered, then pops exactly FRAME_LEN samples using first-word-fall-through (FWFT) reads.
//  For each frame it emits one analysis window: HIST_LEN retained past samples, then FRAME_LEN new samples.

---
 rtl/ads_frame_reader_if.sv | 29 ++
 rtl/ads_frame_reader.sv | 139 +++++++++++++
 tb/tb_ads_frame_reader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ads_frame_reader_if.sv
// Analysis-window output stream of the frame reader.
//   frm_data  : window sample
//   frm_valid : frm_data valid
//   frm_ready : sink accepts on frm_valid & frm_ready
//   frm_sof   : first sample of the window (index 0)
//   frm_eof   : last sample of the window
//   frm_index : position of frm_data within the window
// master = reader side, slave = windowing / autocorrelation side.
interface ads_frame_reader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 8
);
    logic [DATA_W-1:0] frm_data;
    logic              frm_valid;
    logic              frm_ready;
    logic              frm_sof;
    logic              frm_eof;
    logic [IDX_W-1:0]  frm_index;

    modport master (
        output frm_data, frm_valid, frm_sof, frm_eof, frm_index,
        input  frm_ready
    );

    modport slave (
        input  frm_data, frm_valid, frm_sof, frm_eof, frm_index,
        output frm_ready
    );
endinterface

// File: rtl/ads_frame_reader.sv
// Frame reader for the HPF sample FIFO of the G729 encoder front end.
// Waits for a full frame of new samples, then emits one analysis window per
// frame: HIST_LEN retained past samples followed by FRAME_LEN new samples
// popped from the FWFT FIFO. The new samples overwrite the oldest history.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   frm_enable       : allow new frames to start
//   aff_data_count   : samples held in the FIFO
//   aff_data_empty   : FIFO empty
//   aff_read_data    : FIFO head sample (FWFT)
//   lsp_read_en      : FIFO pop (combinational)
//   frm              : window output stream (master modport)
//   frm_count        : completed frames, wraps
//   frm_busy         : high outside IDLE
//   frm_underflow    : pulse when NEW finds the FIFO empty
module ads_frame_reader #(
    parameter int unsigned RAM_ADDR_WIDTH = 10,
    parameter int unsigned RAM_DATA_WIDTH = 32,
    parameter int unsigned FRAME_LEN      = 80,
    parameter int unsigned HIST_LEN       = 160,
    parameter int unsigned IDX_WIDTH      = 8
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      frm_enable,
    input  logic [RAM_ADDR_WIDTH-1:0] aff_data_count,
    input  logic                      aff_data_empty,
    input  logic [RAM_DATA_WIDTH-1:0] aff_read_data,
    output logic                      lsp_read_en,
    ads_frame_reader_if.master        frm,
    output logic [15:0]               frm_count,
    output logic                      frm_busy,
    output logic                      frm_underflow
);
    localparam int unsigned PTR_W = (HIST_LEN > 1) ? $clog2(HIST_LEN) : 1;
    localparam logic [IDX_WIDTH-1:0] HIST_END = IDX_WIDTH'(HIST_LEN - 1);
    localparam logic [IDX_WIDTH-1:0] WIN_END  = IDX_WIDTH'(HIST_LEN + FRAME_LEN - 1);
    localparam logic [PTR_W-1:0]     PTR_END  = PTR_W'(HIST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_HIST, S_NEW, S_DRAIN} state_t;

    state_t                    state, state_nxt;
    logic [RAM_DATA_WIDTH-1:0] hist [HIST_LEN];
    logic [PTR_W-1:0]          hist_ptr;   // oldest history sample
    logic [PTR_W-1:0]          cur_ptr;    // hist_ptr + window position, wrapped
    logic [PTR_W-1:0]          ptr_inc;
    logic [IDX_WIDTH-1:0]      idx;
    logic                      out_ld, start, load_hist, load_new, underflow_c, frame_done;

    assign out_ld  = !frm.frm_valid || frm.frm_ready;
    assign start   = frm_enable && (aff_data_count >= RAM_ADDR_WIDTH'(FRAME_LEN)) && !aff_data_empty;
    assign ptr_inc = (cur_ptr == PTR_END) ? '0 : cur_ptr + 1'b1;

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next state and per-cycle strobes
    always_comb begin
        state_nxt   = state;
        load_hist   = 1'b0;
        load_new    = 1'b0;
        lsp_read_en = 1'b0;
        underflow_c = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_HIST;
            S_HIST: begin
                if (out_ld) begin
                    load_hist = 1'b1;
                    if (idx == HIST_END) state_nxt = S_NEW;
                end
            end
            S_NEW: begin
                if (aff_data_empty) begin
                    underflow_c = 1'b1;
                end else if (out_ld) begin
                    load_new    = 1'b1;
                    lsp_read_en = 1'b1;
                    if (idx == WIN_END) state_nxt = S_DRAIN;
                end
            end
            // Output register empty means the eof sample has been taken.
            S_DRAIN: begin
                if (!frm.frm_valid) begin
                    frame_done = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output register, window pointers, history store and status
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int k = 0; k < HIST_LEN; k++) hist[k] <= '0;
            hist_ptr       <= '0;
            cur_ptr        <= '0;
            idx            <= '0;
            frm.frm_data   <= '0;
            frm.frm_valid  <= 1'b0;
            frm.frm_sof    <= 1'b0;
            frm.frm_eof    <= 1'b0;
            frm.frm_index  <= '0;
            frm_count      <= '0;
            frm_busy       <= 1'b0;
            frm_underflow  <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                idx     <= '0;
                cur_ptr <= hist_ptr;
            end
            if (out_ld) begin
                frm.frm_valid <= load_hist || load_new;
                frm.frm_sof   <= (load_hist || load_new) && (idx == '0);
                frm.frm_eof   <= load_new && (idx == WIN_END);
                if (load_hist || load_new) begin
                    frm.frm_data  <= load_new ? aff_read_data : hist[cur_ptr];
                    frm.frm_index <= idx;
                end
            end
            if (load_hist || load_new) begin
                idx     <= idx + 1'b1;
                cur_ptr <= ptr_inc;
            end
            // New samples replace the oldest history in place.
            if (load_new) begin
                hist[cur_ptr] <= aff_read_data;
                if (idx == WIN_END) hist_ptr <= ptr_inc;
            end
            if (frame_done) frm_count <= frm_count + 16'd1;
            frm_busy      <= (state_nxt != S_IDLE);
            frm_underflow <= underflow_c;
        end
    end
endmodule

// File: tb/tb_ads_frame_reader.sv
// Directed bench for ads_frame_reader with an FWFT FIFO model and a
// history model of the expected analysis windows.
module tb_ads_frame_reader;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned FL = 80;
    localparam int unsigned HL = 160;
    localparam int unsigned IW = 8;
    localparam int unsigned WL = HL + FL;

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
        logic          sof;
        logic          eof;
    } smp_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          frm_enable;
    logic [AW-1:0] aff_data_count;
    logic          aff_data_empty;
    logic [DW-1:0] aff_read_data;
    logic          lsp_read_en;
    logic [15:0]   frm_count;
    logic          frm_busy;
    logic          frm_underflow;

    ads_frame_reader_if #(.DATA_W(DW), .IDX_W(IW)) frm ();

    ads_frame_reader #(
        .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .FRAME_LEN(FL),
        .HIST_LEN(HL), .IDX_WIDTH(IW)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .frm_enable(frm_enable),
        .aff_data_count(aff_data_count), .aff_data_empty(aff_data_empty),
        .aff_read_data(aff_read_data), .lsp_read_en(lsp_read_en),
        .frm(frm), .frm_count(frm_count), .frm_busy(frm_busy),
        .frm_underflow(frm_underflow)
    );

    always #5 sys_clk = ~sys_clk;

    int   n_chk = 0, n_bad = 0;
    int   pops = 0, pop_err = 0, uf_cnt = 0, stable_err = 0;
    logic force_empty = 1'b0, rand_ready = 1'b0;
    int   fifo_q[$];
    int   push_q[$];
    smp_t out_q[$];
    int   exp_hist[HL];

    // FWFT FIFO model: pops on lsp_read_en, then takes queued pushes
    always @(posedge sys_clk) begin
        if (lsp_read_en) begin
            pops++;
            if (fifo_q.size() == 0) pop_err++;
            else void'(fifo_q.pop_front());
        end
        while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
        aff_data_count <= AW'(fifo_q.size());
        aff_data_empty <= (fifo_q.size() == 0) || force_empty;
        aff_read_data  <= (fifo_q.size() > 0) ? DW'(fifo_q[0]) : '0;
    end

    always @(negedge sys_clk)
        frm.frm_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

    // Stream monitor: collects accepted samples, checks hold while stalled
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_d;
    logic [IW-1:0] hold_i;
    always @(posedge sys_clk) begin
        if (!sys_rst) begin
            if (hold_pend && (!frm.frm_valid || frm.frm_data !== hold_d || frm.frm_index !== hold_i))
                stable_err++;
            hold_pend = frm.frm_valid && !frm.frm_ready;
            hold_d    = frm.frm_data;
            hold_i    = frm.frm_index;
            if (frm.frm_valid && frm.frm_ready) begin
                smp_t s;
                s.d = frm.frm_data; s.i = frm.frm_index;
                s.sof = frm.frm_sof; s.eof = frm.frm_eof;
                out_q.push_back(s);
            end
            if (frm_underflow) uf_cnt++;
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic push_n(input int first, input int n);
        for (int k = 0; k < n; k++) push_q.push_back(first + k);
    endtask

    task automatic wait_count(input string tag, input int target, input int budget);
        int c = 0;
        while (frm_count != 16'(target) && c < budget) begin
            @(negedge sys_clk);
            c++;
        end
        chk(tag, 32'(frm_count), 32'(target));
    endtask

    task automatic wait_index(input string tag, input int target, input int budget);
        int c = 0;
        while (!(frm.frm_valid && frm.frm_index == IW'(target)) && c < budget) begin
            @(negedge sys_clk);
            c++;
        end
        chk(tag, 32'(c < budget), 32'd1);
    endtask

    // Compare one window against history model + consecutive new samples
    task automatic check_frame(input string tag, input int first);
        int   exp_w[WL];
        int   derr = 0, ferr = 0, n;
        smp_t s;
        for (int k = 0; k < HL; k++) exp_w[k] = exp_hist[k];
        for (int k = 0; k < FL; k++) exp_w[HL + k] = first + k;
        n = (out_q.size() < WL) ? out_q.size() : WL;
        chk({tag, "_len"}, 32'(n), 32'(WL));
        for (int k = 0; k < n; k++) begin
            s = out_q.pop_front();
            if (s.d !== DW'(exp_w[k])) derr++;
            if (s.i !== IW'(k)) ferr++;
            if (s.sof !== (k == 0)) ferr++;
            if (s.eof !== (k == WL - 1)) ferr++;
        end
        chk({tag, "_data_err"}, 32'(derr), 32'd0);
        chk({tag, "_flag_err"}, 32'(ferr), 32'd0);
        for (int k = 0; k < HL; k++) exp_hist[k] = exp_w[FL + k];
    endtask

    int p0, pf;

    initial begin
        for (int k = 0; k < HL; k++) exp_hist[k] = 0;
        sys_rst = 1'b1;
        frm_enable = 1'b0;
        cycles(3);
        chk("rst_valid", 32'(frm.frm_valid), 0);
        chk("rst_sof_eof", 32'({frm.frm_sof, frm.frm_eof}), 0);
        chk("rst_data", frm.frm_data, 0);
        chk("rst_count", 32'(frm_count), 0);
        chk("rst_busy", 32'(frm_busy), 0);
        chk("rst_rd_en", 32'(lsp_read_en), 0);
        chk("rst_uf", 32'(frm_underflow), 0);
        sys_rst = 1'b0;
        frm_enable = 1'b1;

        // 1) first frame: zero history, then 1..80
        p0 = pops;
        push_n(1, FL);
        wait_count("t1_done", 1, 600);
        check_frame("t1", 1);
        chk("t1_pops", 32'(pops - p0), FL);

        // 2) second frame, history pointer wraps back to 0
        p0 = pops;
        push_n(81, FL);
        wait_count("t2_done", 2, 600);
        check_frame("t2", 81);
        chk("t2_pops", 32'(pops - p0), FL);
        chk("t2_hist_ptr", 32'(dut.hist_ptr), 0);

        // 3) three frames with random backpressure
        p0 = pops;
        rand_ready = 1'b1;
        push_n(161, 3 * FL);
        wait_count("t3_done", 5, 4000);
        rand_ready = 1'b0;
        check_frame("t3a", 161);
        check_frame("t3b", 241);
        check_frame("t3c", 321);
        chk("t3_pops", 32'(pops - p0), 3 * FL);
        chk("t3_stable", 32'(stable_err), 0);

        // 4) one short of a frame, then start latency, then underflow stall
        p0 = pops;
        push_n(401, FL - 1);
        cycles(12);
        chk("t4_no_start", 32'(frm_busy), 0);
        chk("t4_no_pop", 32'(pops - p0), 0);
        push_n(480, 1);
        cycles(1);
        chk("t4_cnt80", 32'(aff_data_count), FL);
        cycles(1);
        chk("t4_lat1_valid", 32'(frm.frm_valid), 0);
        cycles(1);
        chk("t4_lat2_valid", 32'(frm.frm_valid), 1);
        chk("t4_lat2_sof", 32'(frm.frm_sof), 1);
        wait_index("t4_reach_new", HL + 10, 400);
        force_empty = 1'b1;
        cycles(1);
        force_empty = 1'b0;
        pf = pops;
        cycles(1);
        chk("t4_uf_pulse", 32'(frm_underflow), 1);
        chk("t4_stall_valid", 32'(frm.frm_valid), 0);
        chk("t4_stall_pop", 32'(pops - pf), 0);
        cycles(1);
        chk("t4_uf_clear", 32'(frm_underflow), 0);
        chk("t4_resume_valid", 32'(frm.frm_valid), 1);
        wait_count("t4_done", 6, 800);
        check_frame("t4", 401);
        chk("t4_pops", 32'(pops - p0), FL);
        chk("t4_uf_cnt", 32'(uf_cnt), 1);

        // 5) reset mid-window, then a window with cleared history
        p0 = pops;
        push_n(481, FL);
        wait_index("t5_reach", 100, 400);
        sys_rst = 1'b1;
        cycles(1);
        chk("t5_rst_valid", 32'(frm.frm_valid), 0);
        chk("t5_rst_index", 32'(frm.frm_index), 0);
        chk("t5_rst_data", frm.frm_data, 0);
        chk("t5_rst_count", 32'(frm_count), 0);
        chk("t5_rst_busy", 32'(frm_busy), 0);
        chk("t5_rst_rd_en", 32'(lsp_read_en), 0);
        chk("t5_fifo_kept", 32'(fifo_q.size()), FL);
        chk("t5_no_pop", 32'(pops - p0), 0);
        cycles(1);
        out_q.delete();
        for (int k = 0; k < HL; k++) exp_hist[k] = 0;
        sys_rst = 1'b0;
        wait_count("t5_done", 1, 600);
        check_frame("t5", 481);

        // 6) enable dropped mid-window: frame completes, no next frame
        p0 = pops;
        push_n(561, 2 * FL);
        wait_index("t6_reach", 50, 400);
        frm_enable = 1'b0;
        wait_count("t6_done", 2, 600);
        check_frame("t6", 561);
        cycles(20);
        chk("t6_idle_busy", 32'(frm_busy), 0);
        chk("t6_idle_valid", 32'(frm.frm_valid), 0);
        chk("t6_pops", 32'(pops - p0), FL);
        chk("t6_fifo_left", 32'(aff_data_count), FL);
        chk("t6_extra_out", 32'(out_q.size()), 0);

        chk("pop_on_empty", 32'(pop_err), 0);
        chk("hold_stable", 32'(stable_err), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
